// File: rtl/page_dispatcher.sv
// Page dispatcher: offers a commanded page address to the parser and, on page_hit,
// streams the page from the source into a FWFT FIFO; unclaimed pages are discarded.
module page_dispatcher #(
  parameter int unsigned DATA_W      = 256,
  parameter int unsigned PAGE_WORDS  = 128,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned HIT_TIMEOUT = 1024,
  parameter logic [31:0] NULL_ADDR   = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [127:0]      cmd,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [31:0]       read_page_addr,
  input  logic              page_hit,
  input  logic              data_out_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_fifo_empty,
  output logic              busy,
  output logic [31:0]       pages_done,
  output logic [15:0]       drop_count
);

  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned WCW = $clog2(PAGE_WORDS + 1);
  localparam int unsigned TW  = (HIT_TIMEOUT > 1) ? $clog2(HIT_TIMEOUT) : 1;

  localparam logic [AW:0]     FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [WCW-1:0]  W_LAST   = WCW'(PAGE_WORDS - 1);
  localparam logic [TW-1:0]   T_LAST   = TW'(HIT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    OFFER,
    STREAM,
    DRAIN,
    DROP
  } state_t;

  state_t         state;
  logic [TW-1:0]  tcnt;
  logic [WCW-1:0] word_cnt;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              fifo_full;
  logic              push;
  logic              pop;
  logic              unused_cmd;

  assign unused_cmd = ^cmd[127:32];

  assign fifo_full       = (count == FULL_CNT);
  assign data_fifo_empty = (count == '0);
  assign push            = src_valid && src_ready && (state == STREAM);
  assign pop             = data_out_en && !data_fifo_empty;
  assign busy            = (state != IDLE);
  // Head word is forced to zero while empty so data_out is clean after reset.
  assign data_out        = data_fifo_empty ? '0 : mem[rd_ptr];

  always_comb begin
    src_ready = 1'b0;
    case (state)
      STREAM:  src_ready = !fifo_full;
      DROP:    src_ready = 1'b1;
      default: src_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= src_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + (AW + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      read_page_addr <= NULL_ADDR;
      cmd_ready      <= 1'b0;
      tcnt           <= '0;
      word_cnt       <= '0;
      pages_done     <= '0;
      drop_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready      <= 1'b1;
          read_page_addr <= NULL_ADDR;
          if (cmd_valid && cmd_ready) begin
            read_page_addr <= cmd[31:0];
            tcnt           <= '0;
            cmd_ready      <= 1'b0;
            state          <= OFFER;
          end
        end
        OFFER: begin
          // A hit in the expiry cycle still wins over the timeout.
          if (page_hit) begin
            word_cnt <= '0;
            state    <= STREAM;
          end else if ((HIT_TIMEOUT != 0) && (tcnt == T_LAST)) begin
            word_cnt <= '0;
            state    <= DROP;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        STREAM: begin
          if (push) begin
            word_cnt <= word_cnt + WCW'(1);
            if (word_cnt == W_LAST) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (data_fifo_empty) begin
            state          <= IDLE;
            pages_done     <= pages_done + 32'd1;
            read_page_addr <= NULL_ADDR;
            cmd_ready      <= 1'b1;
          end
        end
        DROP: begin
          if (src_valid) begin
            word_cnt <= word_cnt + WCW'(1);
            if (word_cnt == W_LAST) begin
              state          <= IDLE;
              read_page_addr <= NULL_ADDR;
              cmd_ready      <= 1'b1;
              if (drop_count != 16'hFFFF) begin
                drop_count <= drop_count + 16'd1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
